// File: rtl/alu_result_buffer.sv
// Registered output stage for the ALU: captures result + opcode tag and hands them
// to writeback over valid/ready, with a 2-entry skid buffer so in_ready is fully registered.
module alu_result_buffer #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OP_W-1:0]  out_op,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_n_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_result_r;
    logic [OP_W-1:0]    out_op_r;
    logic               out_zero_r;
    logic [WIDTH-1:0]   skid_result_r;
    logic [OP_W-1:0]    skid_op_r;
    logic [CNT_W-1:0]   count_r;

    logic               push_s;
    logic               pop_s;
    logic               load_head_in_s;
    logic               load_head_skid_s;
    logic               load_skid_s;
    logic [WIDTH-1:0]   head_result_s;
    logic [OP_W-1:0]    head_op_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Next-state and register-load decode; flush overrides every other event.
    always_comb begin
        state_n_s        = state_r;
        load_head_in_s   = 1'b0;
        load_head_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_n_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_n_s      = ST_ONE;
                        load_head_in_s = 1'b1;
                    end else begin
                        state_n_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && !pop_s) begin
                        state_n_s   = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (!push_s && pop_s) begin
                        state_n_s = ST_EMPTY;
                    end else if (push_s && pop_s) begin
                        state_n_s      = ST_ONE;
                        load_head_in_s = 1'b1;
                    end else begin
                        state_n_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_n_s        = ST_ONE;
                        load_head_skid_s = 1'b1;
                    end else begin
                        state_n_s = ST_FULL;
                    end
                end
                default: begin
                    state_n_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Head entry source: the skid entry drains ahead of any new input.
    always_comb begin
        if (load_head_skid_s) begin
            head_result_s = skid_result_r;
            head_op_s     = skid_op_r;
        end else begin
            head_result_s = in_result;
            head_op_s     = in_op;
        end
    end

    // State and handshake flags; ready/valid are decoded from the next state so both stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            in_ready_r  <= (state_n_s != ST_FULL);
            out_valid_r <= (state_n_s != ST_EMPTY);
        end
    end

    // Head and skid data; the zero flag is derived from the value being loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_r  <= {WIDTH{1'b0}};
            out_op_r      <= {OP_W{1'b0}};
            out_zero_r    <= 1'b1;
            skid_result_r <= {WIDTH{1'b0}};
            skid_op_r     <= {OP_W{1'b0}};
        end else begin
            if (load_head_in_s || load_head_skid_s) begin
                out_result_r <= head_result_s;
                out_op_r     <= head_op_s;
                out_zero_r   <= (head_result_s == {WIDTH{1'b0}});
            end
            if (load_skid_s) begin
                skid_result_r <= in_result;
                skid_op_r     <= in_op;
            end
        end
    end

    // Delivered-result counter; a pop that coincides with flush was still seen by writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_op     = out_op_r;
    assign out_zero   = out_zero_r;
    assign out_count  = count_r;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: a queue model of a depth-2 FIFO is checked
// by a negedge monitor while directed and random stimulus runs in a separate process.
module tb_alu_result_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = 32'd0;
    logic [3:0]  in_op = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_op;
    logic        out_zero;
    logic [15:0] out_count;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  op;
    } item_t;

    item_t       exp_q[$];
    logic [15:0] exp_count = 16'd0;
    int          total_pops = 0;
    int          vectors = 0;
    int          miscompares = 0;

    alu_result_buffer #(.WIDTH(32), .OP_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_op(out_op), .out_zero(out_zero), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the FIFO model mid-cycle, then apply this cycle's handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < 2)});
            check("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() > 0)});
            check("out_count", {16'd0, out_count}, {16'd0, exp_count});
            if (out_valid && exp_q.size() > 0) begin
                check("out_result", out_result, exp_q[0].res);
                check("out_op", {28'd0, out_op}, {28'd0, exp_q[0].op});
                check("out_zero", {31'd0, out_zero}, {31'd0, (exp_q[0].res == 32'd0)});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                exp_count  = exp_count + 16'd1;
                total_pops = total_pops + 1;
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back('{res: in_result, op: in_op});
        end
    end

    task automatic cyc(input logic v, input logic [31:0] r, input logic [3:0] o,
                       input logic rdy, input logic fl);
        in_valid  = v;
        in_result = r;
        in_op     = o;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset asynchronously, checks reset values before any clock edge, then releases.
    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        exp_q.delete();
        exp_count = 16'd0;
        total_pops = 0;
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_result", out_result, 32'd0);
        check("rst out_op", {28'd0, out_op}, 32'd0);
        check("rst out_zero", {31'd0, out_zero}, 32'd1);
        check("rst out_count", {16'd0, out_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, b, c, ones, zr;
        logic [15:0] c0;
        int sh;
        int budget;

        #1;
        do_reset();

        // First result with writeback ready
        a = 32'h8C30D763 << 2;
        cyc(1'b1, a, 4'd1, 1'b1, 1'b0);
        check("first out_result", out_result, 32'h30C35D8C);
        check("first out_zero", {31'd0, out_zero}, 32'd0);
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        check("first count", {16'd0, out_count}, 32'd1);

        // Back-to-back stream of 8
        c0 = out_count;
        for (int i = 0; i < 8; i++) begin
            check("stream in_ready", {31'd0, in_ready}, 32'd1);
            cyc(1'b1, $urandom, 4'(i), 1'b1, 1'b0);
        end
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        check("stream count", {16'd0, out_count}, {16'd0, c0 + 16'd8});

        // Fill to FULL under back-pressure, then drain
        a = $urandom; b = $urandom;
        cyc(1'b1, a, 4'd3, 1'b0, 1'b0);
        cyc(1'b1, b, 4'd4, 1'b0, 1'b0);
        check("full in_ready", {31'd0, in_ready}, 32'd0);
        cyc(1'b0, 32'd0, 4'd0, 1'b0, 1'b0);
        check("full head stable", out_result, a);
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        check("after pop A head", out_result, b);
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        check("drained in_ready", {31'd0, in_ready}, 32'd1);
        check("drained out_valid", {31'd0, out_valid}, 32'd0);

        // Zero result from an out-of-range shift, then a non-zero one
        ones = 32'hFFFF_FFFF; sh = 32;
        zr = ones << sh;
        cyc(1'b1, zr, 4'd0, 1'b1, 1'b0);
        check("zero result", out_result, 32'd0);
        check("zero flag set", {31'd0, out_zero}, 32'd1);
        cyc(1'b1, 32'd1, 4'd0, 1'b1, 1'b0);
        check("zero flag clear", {31'd0, out_zero}, 32'd0);
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

        // Flush with a coincident pop while FULL
        a = $urandom; b = $urandom; c = $urandom;
        cyc(1'b1, a, 4'd5, 1'b0, 1'b0);
        cyc(1'b1, b, 4'd6, 1'b0, 1'b0);
        c0 = out_count;
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b1);
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        check("flush in_ready", {31'd0, in_ready}, 32'd1);
        check("flush count", {16'd0, out_count}, {16'd0, c0 + 16'd1});
        cyc(1'b1, c, 4'd7, 1'b0, 1'b0);
        check("post-flush valid", {31'd0, out_valid}, 32'd1);
        check("post-flush result", out_result, c);
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

        // Asynchronous reset between edges while FULL
        cyc(1'b1, $urandom, 4'd8, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 4'd9, 1'b0, 1'b0);
        #2;
        do_reset();

        // Randomised traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, (($urandom % 8) == 0) ? 32'd0 : $urandom,
                4'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
        end
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

        // Counter wrap after 65536 pops
        do_reset();
        budget = 70000;
        while (total_pops < 65536 && budget > 0) begin
            cyc(1'b1, $urandom, 4'($urandom), 1'b1, 1'b0);
            budget--;
        end
        check("wrap budget", {31'd0, (budget > 0)}, 32'd1);
        check("wrap count", {16'd0, out_count}, 32'd0);

        budget = 8;
        while (exp_q.size() > 0 && budget > 0) begin
            cyc(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
            budget--;
        end
        check("drain empty", exp_q.size(), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
